// File: rtl/striping_pkg.sv
// Shared types and constants for the two-lane striping front end.
package striping_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned NumLanes = 2;

  localparam logic [DataW-1:0] PadWordDefault = 32'hBCBC_BCBC;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServe0 = 2'd1,
    StServe1 = 2'd2,
    StPad    = 2'd3
  } arb_state_e;

  // Source to grant from IDLE; rr names the source served last, so a tie goes to the other one.
  function automatic logic pick_source(input logic r0, input logic r1, input logic rr);
    if (r0 && r1) begin
      return ~rr;
    end
    return r1;
  endfunction

endpackage

// File: rtl/striping_arbiter_c.sv
// Packet-level round-robin arbiter feeding the two-lane byte striper; pads odd-length packets
// so that every packet starts on lane 0.
module striping_arbiter_c
  import striping_pkg::*;
#(
  parameter logic [DataW-1:0] PAD_WORD = PadWordDefault
) (
  input  logic             clk_2f_c,
  input  logic             reset,
  input  logic             req_0,
  input  logic [DataW-1:0] data_0,
  input  logic             last_0,
  output logic             pop_0,
  input  logic             req_1,
  input  logic [DataW-1:0] data_1,
  input  logic             last_1,
  output logic             pop_1,
  output logic             valid_out,
  output logic [DataW-1:0] data_out,
  output logic             lane_par,
  output logic             busy
);

  localparam int unsigned LaneBits = $clog2(NumLanes);

  arb_state_e          state_q, state_d;
  logic                rr_q, rr_d;
  logic [LaneBits-1:0] lane_q, lane_d;
  logic                valid_q, valid_d;
  logic [DataW-1:0]    data_q, data_d;

  logic                sel;
  logic                cur_req;
  logic                cur_last;
  logic [DataW-1:0]    cur_data;

  // Mux of the source currently owning the striper; only meaningful in SERVE states.
  always_comb begin
    sel      = (state_q == StServe1);
    cur_req  = sel ? req_1 : req_0;
    cur_last = sel ? last_1 : last_0;
    cur_data = sel ? data_1 : data_0;
  end

  // Pops and busy are masked while reset is held so a mid-packet reset consumes nothing.
  always_comb begin
    pop_0 = reset & (state_q == StServe0) & req_0;
    pop_1 = reset & (state_q == StServe1) & req_1;
    busy  = reset & (state_q != StIdle);
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lane_d  = lane_q;
    valid_d = 1'b0;
    data_d  = '0;

    case (state_q)
      StIdle: begin
        if (req_0 || req_1) begin
          state_d = pick_source(req_0, req_1, rr_q) ? StServe1 : StServe0;
        end
      end

      StServe0, StServe1: begin
        if (cur_req) begin
          valid_d = 1'b1;
          data_d  = cur_data;
          lane_d  = lane_q + 1'b1;
          if (cur_last) begin
            rr_d = sel;
            // A last word landing on lane 0 leaves the packet odd; lane 1 must be filled.
            state_d = (lane_q == '0) ? StPad : StIdle;
          end
        end
      end

      StPad: begin
        valid_d = 1'b1;
        data_d  = PAD_WORD;
        lane_d  = lane_q + 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_2f_c) begin
    if (!reset) begin
      state_q <= StIdle;
      rr_q    <= 1'b1;
      lane_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      lane_q  <= lane_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign lane_par  = lane_q[0];

endmodule

// File: tb/tb_striping_arbiter_c.sv
// Scoreboard bench for striping_arbiter_c: directed packets, expected words queued at issue time.
module tb_striping_arbiter_c;

  typedef struct {
    logic [31:0] data;
    logic        lane;
  } exp_t;

  localparam logic [31:0] Pad = 32'hBCBC_BCBC;

  logic        clk_2f_c;
  logic        reset;
  logic        req_0, req_1;
  logic [31:0] data_0, data_1;
  logic        last_0, last_1;
  logic        pop_0, pop_1;
  logic        valid_out;
  logic [31:0] data_out;
  logic        lane_par;
  logic        busy;

  int checks;
  int failures;
  exp_t exp_q[$];

  striping_arbiter_c #(
    .PAD_WORD(Pad)
  ) dut (
    .clk_2f_c (clk_2f_c),
    .reset    (reset),
    .req_0    (req_0),
    .data_0   (data_0),
    .last_0   (last_0),
    .pop_0    (pop_0),
    .req_1    (req_1),
    .data_1   (data_1),
    .last_1   (last_1),
    .pop_1    (pop_1),
    .valid_out(valid_out),
    .data_out (data_out),
    .lane_par (lane_par),
    .busy     (busy)
  );

  initial clk_2f_c = 1'b0;
  always #5 clk_2f_c = ~clk_2f_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic lane);
    exp_t e;
    e.data = d;
    e.lane = lane;
    exp_q.push_back(e);
  endtask

  // Monitor: every presented word is matched against the head of the scoreboard.
  always @(negedge clk_2f_c) begin
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h required=none", data_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word_data", data_out, e.data);
        check("word_lane", 32'(lane_par), 32'(e.lane));
      end
    end
  end

  // One clock cycle: drive sources, check combinational outputs mid-cycle, and optionally the
  // registered valid/lane state (ev < 0 skips that).
  task automatic step(input string tag,
                      input logic r0, input logic [31:0] d0, input logic l0,
                      input logic r1, input logic [31:0] d1, input logic l1,
                      input logic ep0, input logic ep1, input logic eb,
                      input int ev, input int el);
    req_0  = r0;
    data_0 = d0;
    last_0 = l0;
    req_1  = r1;
    data_1 = d1;
    last_1 = l1;
    @(negedge clk_2f_c);
    check({tag, "_pop0"}, 32'(pop_0), 32'(ep0));
    check({tag, "_pop1"}, 32'(pop_1), 32'(ep1));
    check({tag, "_busy"}, 32'(busy), 32'(eb));
    if (ev >= 0) begin
      check({tag, "_valid"}, 32'(valid_out), 32'(ev));
      check({tag, "_lane"}, 32'(lane_par), 32'(el));
      if (ev == 0) check({tag, "_data0"}, data_out, 32'h0);
    end
    @(posedge clk_2f_c);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    req_0 = 1'b0; data_0 = '0; last_0 = 1'b0;
    req_1 = 1'b0; data_1 = '0; last_1 = 1'b0;
    @(posedge clk_2f_c);
    @(posedge clk_2f_c);
    #1;

    // Reset state, with a request present to show pops stay low
    step("rst", 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Reset mid-packet: 3-word packet from source 0, reset after 2nd pop
    step("mr_idle", 1, 32'h10, 0, 0, 0, 0, 0, 0, 0, -1, 0);
    push(32'h10, 1'b1);
    step("mr_w0", 1, 32'h10, 0, 0, 0, 0, 1, 0, 1, -1, 0);
    push(32'h20, 1'b0);
    step("mr_w1", 1, 32'h20, 0, 0, 0, 0, 1, 0, 1, -1, 0);
    reset = 1'b0;
    step("mr_rst", 1, 32'h30, 1, 1, 32'hB0, 1, 0, 0, 0, -1, 0);
    reset = 1'b1;
    step("mr_after", 0, 0, 0, 1, 32'hB0, 1, 0, 0, 0, 0, 0);
    push(32'hB0, 1'b1);
    step("mr_s1", 0, 0, 0, 1, 32'hB0, 1, 0, 1, 1, -1, 0);
    push(Pad, 1'b0);
    step("mr_pad", 0, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0);
    step("mr_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);

    // Even packet from source 0
    step("ev_idle", 1, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0, -1, 0);
    push(32'h1111_1111, 1'b1);
    step("ev_w0", 1, 32'h1111_1111, 0, 0, 0, 0, 1, 0, 1, -1, 0);
    push(32'h2222_2222, 1'b0);
    step("ev_w1", 1, 32'h2222_2222, 0, 0, 0, 0, 1, 0, 1, -1, 0);
    push(32'h3333_3333, 1'b1);
    step("ev_w2", 1, 32'h3333_3333, 0, 0, 0, 0, 1, 0, 1, -1, 0);
    push(32'h4444_4444, 1'b0);
    step("ev_w3", 1, 32'h4444_4444, 1, 0, 0, 0, 1, 0, 1, -1, 0);
    step("ev_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);

    // Odd packet from source 1, padded
    step("od_idle", 0, 0, 0, 1, 32'hA0, 0, 0, 0, 0, 0, 0);
    push(32'hA0, 1'b1);
    step("od_w0", 0, 0, 0, 1, 32'hA0, 0, 0, 1, 1, -1, 0);
    push(32'hA1, 1'b0);
    step("od_w1", 0, 0, 0, 1, 32'hA1, 0, 0, 1, 1, -1, 0);
    push(32'hA2, 1'b1);
    step("od_w2", 0, 0, 0, 1, 32'hA2, 1, 0, 1, 1, -1, 0);
    push(Pad, 1'b0);
    step("od_pad", 0, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0);
    step("od_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);

    // Both sources requesting 2-word packets: grants 0, 1, 0, 1
    step("rr_i0", 1, 32'hC0, 0, 1, 32'hD0, 0, 0, 0, 0, -1, 0);
    push(32'hC0, 1'b1);
    step("rr_c0", 1, 32'hC0, 0, 1, 32'hD0, 0, 1, 0, 1, -1, 0);
    push(32'hC1, 1'b0);
    step("rr_c1", 1, 32'hC1, 1, 1, 32'hD0, 0, 1, 0, 1, -1, 0);
    step("rr_i1", 1, 32'hC2, 0, 1, 32'hD0, 0, 0, 0, 0, -1, 0);
    push(32'hD0, 1'b1);
    step("rr_d0", 1, 32'hC2, 0, 1, 32'hD0, 0, 0, 1, 1, -1, 0);
    push(32'hD1, 1'b0);
    step("rr_d1", 1, 32'hC2, 0, 1, 32'hD1, 1, 0, 1, 1, -1, 0);
    step("rr_i2", 1, 32'hC2, 0, 1, 32'hD2, 0, 0, 0, 0, -1, 0);
    push(32'hC2, 1'b1);
    step("rr_c2", 1, 32'hC2, 0, 1, 32'hD2, 0, 1, 0, 1, -1, 0);
    push(32'hC3, 1'b0);
    step("rr_c3", 1, 32'hC3, 1, 1, 32'hD2, 0, 1, 0, 1, -1, 0);
    step("rr_i3", 0, 0, 0, 1, 32'hD2, 0, 0, 0, 0, -1, 0);
    push(32'hD2, 1'b1);
    step("rr_d2", 0, 0, 0, 1, 32'hD2, 0, 0, 1, 1, -1, 0);
    push(32'hD3, 1'b0);
    step("rr_d3", 0, 0, 0, 1, 32'hD3, 1, 0, 1, 1, -1, 0);
    step("rr_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);

    // Underflow: req_0 drops for 2 cycles inside a 2-word packet
    step("uf_idle", 1, 32'hE0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
    push(32'hE0, 1'b1);
    step("uf_w0", 1, 32'hE0, 0, 0, 0, 0, 1, 0, 1, -1, 0);
    step("uf_gap0", 0, 32'hE1, 0, 0, 0, 0, 0, 0, 1, -1, 0);
    step("uf_gap1", 0, 32'hE1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    push(32'hE1, 1'b0);
    step("uf_w1", 1, 32'hE1, 1, 0, 0, 0, 1, 0, 1, 0, 1);
    step("uf_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
    step("uf_nopad", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single-word packets back-to-back from source 1
    step("sw_i0", 0, 0, 0, 1, 32'hF0, 1, 0, 0, 0, -1, 0);
    push(32'hF0, 1'b1);
    step("sw_w0", 0, 0, 0, 1, 32'hF0, 1, 0, 1, 1, -1, 0);
    push(Pad, 1'b0);
    step("sw_p0", 0, 0, 0, 1, 32'hF1, 1, 0, 0, 1, -1, 0);
    step("sw_i1", 0, 0, 0, 1, 32'hF1, 1, 0, 0, 0, -1, 0);
    push(32'hF1, 1'b1);
    step("sw_w1", 0, 0, 0, 1, 32'hF1, 1, 0, 1, 1, -1, 0);
    push(Pad, 1'b0);
    step("sw_p1", 0, 0, 0, 0, 0, 0, 0, 0, 1, -1, 0);
    step("sw_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0);
    step("sw_quiet", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/striping_arbiter_c.md
# striping_arbiter_c

Packet-level arbiter and sequencer placed in front of the two-lane byte striper. It shares the striper between two word-stream sources using round-robin arbitration at packet boundaries, and drives the striper's `valid_in`/`Data_in`. It inserts a pad word after any odd-length packet, so every packet starts on lane 0. It also tracks the striper's lane parity internally.

## Interface
Parameters:
- `PAD_WORD`, default `32'hBC_BC_BC_BC`, filler word emitted to complete an odd-length packet.

Ports:
- `clk_2f_c`  in  1  single clock, the striper's 2f domain.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk_2f_c`.
- `req_0`  in  1  source 0 has a word available on `data_0`.
- `data_0`  in  32  source 0 word.
- `last_0`  in  1  `data_0` is the final word of its packet.
- `pop_0`  out  1  combinational; word on `data_0` is consumed this cycle.
- `req_1`, `data_1`, `last_1`, `pop_1`: same as the source 0 ports, for source 1.
- `valid_out`  out  1  registered; connects to the striper's `valid_in`.
- `data_out`  out  32  registered; connects to the striper's `Data_in`.
- `lane_par`  out  1  registered; lane the next valid word lands on (0 = lane 0).
- `busy`  out  1  combinational; state is not IDLE.

## Operation
- States: IDLE, SERVE_0, SERVE_1, PAD.
- Round-robin pointer `rr` names the source that was served last. Reset value is 1, so source 0 wins the first tie.
- IDLE:
  - If only one `req_x` is high, go to SERVE_x.
  - If both are high, go to SERVE of the source not equal to `rr`.
  - If neither is high, stay.
  - No pop occurs in IDLE.
- SERVE_x:
  - `pop_x` = `req_x`. The other source's pop is 0.
  - On a popped word, the next edge registers `data_out` = `data_x`, `valid_out` = 1, and toggles `lane_par`.
  - If `req_x` is low (source underflow), the next edge registers `valid_out` = 0 and `data_out` = 0. `lane_par` holds and the state holds.
  - On a popped word with `last_x` = 1:
    - `rr` <= x.
    - If `lane_par` is currently 0 (word goes to lane 0), go to PAD. Otherwise go to IDLE.
- PAD: the next edge registers `valid_out` = 1, `data_out` = `PAD_WORD`, and toggles `lane_par` (back to 0). Then go to IDLE. No pops occur.
- Outside word cycles, `valid_out` = 0 and `data_out` = 0.
- `lane_par` toggles exactly on every registered `valid_out` = 1. It mirrors the striper's internal lane counter.
- In IDLE, `lane_par` is 0 by construction.
- The arbiter never switches source mid-packet, regardless of the other source's `req`.

## Timing
- Reset (`reset` = 0 at an edge) forces: state IDLE, `rr` = 1, `lane_par` = 0, `valid_out` = 0, `data_out` = 0. During reset, `pop_0`/`pop_1` are 0 and `busy` is 0.
- Reset asserted mid-packet abandons the packet with no pad word. The source is responsible for flushing its remaining words.
- Latency is one cycle from `pop_x` to the word on `data_out`/`valid_out`.
- Per-packet overhead:
  - One IDLE cycle before each packet.
  - One PAD cycle after each odd-length packet.
- A packet of N words with no underflow occupies 1 + N + (N mod 2) cycles.
- Back-to-back packets from alternating sources are sustained with no extra gap beyond the IDLE cycle.
- A 1-word packet takes: IDLE, SERVE (pop with last), PAD, IDLE.
- `req`/`last` are sampled in the same cycle as the pop. `last_x` is ignored when `req_x` = 0.

## Structure
- Shared package `striping_pkg`:
  - State encoding enum: IDLE=2'd0, SERVE_0=2'd1, SERVE_1=2'd2, PAD=2'd3.
  - `PAD_WORD` default constant.
  - Lane-count constant (2).
- A single module with no sub-modules. The tie-break logic is too small to justify a separate arbiter module.
- Top-level integration instantiates `striping_arbiter_c` feeding `byte_striping_c` on the same `clk_2f_c`/`reset`.

## Test plan
- Reset mid-packet:
  - Stimulus: 3-word packet from source 0, with `reset` = 0 asserted after the 2nd pop.
  - Response: next edge gives `valid_out` = 0 and IDLE; `lane_par` = 0; no PAD word is emitted.
  - Release reset with only `req_1` high. Response: source 1 is served first.
- Even packet, source 0 only: words `32'h11111111`..`32'h44444444` with `last` on the 4th.
  - Response: 4 valid words in order, one per cycle after 1 IDLE cycle.
  - No pad; `lane_par` returns to 0.
- Odd packet: 3 words `A0`, `A1`, `A2` from source 1.
  - Response: `valid_out` words are A0, A1, A2, then `32'hBCBCBCBC`.
  - `lane_par` sequence 1, 0, 1, 0.
- Simultaneous requests: both sources continuously requesting 2-word packets.
  - Response: grant order 0, 1, 0, 1.
  - No pop on the idle source while the other's packet is in progress.
- Underflow: source 0 drops `req_0` for 2 cycles between words 1 and 2 of a 2-word packet.
  - Response: `valid_out` = 0 for 2 cycles; state stays SERVE_0; `lane_par` holds at 1; no pad afterwards.
- Single-word packets back-to-back from source 1.
  - Response: each packet gives data, then PAD, then IDLE; 3 cycles per packet.
